imem_responder: RTL and testbench

//  Instruction-memory responder: the memory end of the fetch read interface (rd_addr/rd_enable ->
//  rd_data/rd_ready). Serves one word read per request after a programmable latency from an

---
 rtl/imem_responder_pkg.sv | 31 +++
 rtl/imem_responder_array.sv | 27 ++
 rtl/imem_responder.sv | 125 ++++++++++++
 tb/tb_imem_responder.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/imem_responder_pkg.sv
// Shared definitions for the instruction-memory responder: bus widths, default
// geometry, FSM state encoding and the byte-address to word-index mapping.
package imem_responder_pkg;

   localparam int unsigned ADDR_SIZE    = 31;
   localparam int unsigned INSTR_SIZE   = 31;
   localparam int unsigned IMEM_DEPTH   = 1024;
   localparam int unsigned IMEM_LATENCY = 2;
   localparam logic [ADDR_SIZE:0] IMEM_BASE = 32'h0000_0000;

   typedef enum logic [1:0] {
      ImemIdle,
      ImemWait,
      ImemResp
   } imem_state_e;

   // Offset from the base wraps on underflow, so low addresses land far out of range.
   function automatic logic [ADDR_SIZE:0] word_index(input logic [ADDR_SIZE:0] addr,
                                                    input logic [ADDR_SIZE:0] base);
      logic [ADDR_SIZE:0] off;
      off = addr - base;
      return off >> 2;
   endfunction

   function automatic logic in_range(input logic [ADDR_SIZE:0] addr,
                                     input logic [ADDR_SIZE:0] base,
                                     input logic [ADDR_SIZE:0] depth);
      return (addr >= base) && (word_index(addr, base) < depth);
   endfunction

endpackage

// File: rtl/imem_responder_array.sv
// Word storage for the instruction memory: synchronous write, asynchronous read.
// A read in the same cycle as a write to that word returns the old contents.
module imem_array
   import imem_responder_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = IMEM_DEPTH,
   parameter int unsigned IDX_W       = $clog2(IMEM_DEPTH)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [IDX_W-1:0]      waddr,
   input  logic [INSTR_SIZE:0]   wdata,
   input  logic [IDX_W-1:0]      raddr,
   output logic [INSTR_SIZE:0]   rdata
);

   logic [INSTR_SIZE:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/imem_responder.sv
// Memory end of the fetch read interface: one word per request after LATENCY
// cycles, with a preload port for program images.
module imem_responder
   import imem_responder_pkg::*;
#(
   parameter int unsigned        DEPTH_WORDS = IMEM_DEPTH,
   parameter int unsigned        LATENCY     = IMEM_LATENCY,
   parameter logic [ADDR_SIZE:0] BASE_ADDR   = IMEM_BASE
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [ADDR_SIZE:0]  rd_addr,
   input  logic                rd_enable,
   output logic [INSTR_SIZE:0] rd_data,
   output logic                rd_ready,
   output logic                rd_err,
   input  logic                ld_en,
   input  logic [ADDR_SIZE:0]  ld_addr,
   input  logic [INSTR_SIZE:0] ld_data
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
   localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [ADDR_SIZE:0] DEPTH_A = DEPTH_WORDS;

   imem_state_e         state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ADDR_SIZE:0]  addr_q, addr_d;
   logic [INSTR_SIZE:0] data_q, data_d;
   logic                ready_q, ready_d;
   logic                err_q, err_d;

   logic [ADDR_SIZE:0]  lookup_addr;
   logic [IDX_W-1:0]    rd_idx, ld_idx;
   logic                rd_ok, ld_ok, enter_resp;
   logic [INSTR_SIZE:0] arr_rdata;

   // With LATENCY=1 the response is latched on the accept edge, before addr_q is valid.
   assign lookup_addr = (state_q == ImemIdle) ? rd_addr : addr_q;
   assign rd_idx      = IDX_W'(word_index(lookup_addr, BASE_ADDR));
   assign rd_ok       = in_range(lookup_addr, BASE_ADDR, DEPTH_A);
   assign ld_idx      = IDX_W'(word_index(ld_addr, BASE_ADDR));
   assign ld_ok       = in_range(ld_addr, BASE_ADDR, DEPTH_A);

   imem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_array (
      .clk   (clk),
      .we    (ld_en && ld_ok),
      .waddr (ld_idx),
      .wdata (ld_data),
      .raddr (rd_idx),
      .rdata (arr_rdata)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ImemIdle;
         cnt_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         ready_q <= ready_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      data_d     = data_q;
      ready_d    = ready_q;
      err_d      = err_q;
      enter_resp = 1'b0;
      unique case (state_q)
         ImemIdle: begin
            if (rd_enable) begin
               addr_d = rd_addr;
               cnt_d  = CNT_W'(LATENCY - 1);
               if (LATENCY == 1) begin
                  enter_resp = 1'b1;
               end else begin
                  state_d = ImemWait;
               end
            end
         end
         ImemWait: begin
            if (!rd_enable) begin
               state_d = ImemIdle;
            end else if (cnt_q == '0) begin
               enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ImemResp: begin
            if (!rd_enable) begin
               state_d = ImemIdle;
               ready_d = 1'b0;
               err_d   = 1'b0;
            end
         end
         default: state_d = ImemIdle;
      endcase
      if (enter_resp) begin
         state_d = ImemResp;
         ready_d = 1'b1;
         data_d  = rd_ok ? arr_rdata : '0;
         err_d   = !rd_ok;
      end
   end

   assign rd_data  = data_q;
   assign rd_ready = ready_q;
   assign rd_err   = err_q;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder (DEPTH_WORDS=1024, LATENCY=2, BASE_ADDR=0):
// hand-computed responses, aborts, out-of-range, load/read collision and reset.
module tb_imem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] rd_addr;
   logic        rd_enable;
   logic [31:0] rd_data;
   logic        rd_ready;
   logic        rd_err;
   logic        ld_en;
   logic [31:0] ld_addr;
   logic [31:0] ld_data;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   imem_responder #(
      .DEPTH_WORDS (1024),
      .LATENCY     (2),
      .BASE_ADDR   (32'h0000_0000)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rd_addr   (rd_addr),
      .rd_enable (rd_enable),
      .rd_data   (rd_data),
      .rd_ready  (rd_ready),
      .rd_err    (rd_err),
      .ld_en     (ld_en),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Advance one edge and settle past it before sampling or driving.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [31:0] a, input logic [31:0] d);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      tick();
      ld_en = 1'b0;
   endtask

   // Full request at LATENCY=2: not ready after N and N+1, ready after N+2.
   task automatic request(input string tag, input logic [31:0] a,
                          input logic [31:0] exp_d, input logic exp_e);
      rd_addr = a; rd_enable = 1'b1;
      tick();
      check({tag, "_n0_ready"}, {31'b0, rd_ready}, 32'd0);
      tick();
      check({tag, "_n1_ready"}, {31'b0, rd_ready}, 32'd0);
      tick();
      check({tag, "_ready"}, {31'b0, rd_ready}, 32'd1);
      check({tag, "_data"},  rd_data, exp_d);
      check({tag, "_err"},   {31'b0, rd_err}, {31'b0, exp_e});
      rd_enable = 1'b0;
      tick();
      check({tag, "_release"}, {31'b0, rd_ready}, 32'd0);
   endtask

   initial begin
      reset = 1'b1; rd_addr = '0; rd_enable = 1'b0;
      ld_en = 1'b0; ld_addr = '0; ld_data = '0;
      // Loads are legal during reset.
      load(32'h0, 32'h0000_0013);
      load(32'h4, 32'h0010_0093);
      load(32'h8, 32'h1111_1111);
      load(32'hC, 32'h0020_0113);
      load(32'h1000, 32'hBAD0_BAD0);  // dropped: out of range
      check("reset_ready", {31'b0, rd_ready}, 32'd0);
      check("reset_data",  rd_data, 32'd0);
      check("reset_err",   {31'b0, rd_err}, 32'd0);
      reset = 1'b0;
      tick();

      // 1: basic read with data held stable while enabled
      rd_addr = 32'h4; rd_enable = 1'b1;
      tick();
      check("t1_n0_ready", {31'b0, rd_ready}, 32'd0);
      tick();
      check("t1_n1_ready", {31'b0, rd_ready}, 32'd0);
      tick();
      check("t1_ready", {31'b0, rd_ready}, 32'd1);
      check("t1_data",  rd_data, 32'h0010_0093);
      check("t1_err",   {31'b0, rd_err}, 32'd0);
      for (int i = 0; i < 2; i++) begin
         tick();
         check("t1_hold_ready", {31'b0, rd_ready}, 32'd1);
         check("t1_hold_data",  rd_data, 32'h0010_0093);
      end
      rd_enable = 1'b0;
      tick();
      check("t1_rel_ready", {31'b0, rd_ready}, 32'd0);
      check("t1_rel_data",  rd_data, 32'h0010_0093);

      // 2: abort in WAIT, then a clean request
      rd_addr = 32'h0; rd_enable = 1'b1;
      tick();
      rd_enable = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t2_abort_ready", {31'b0, rd_ready}, 32'd0);
      end
      request("t2_after", 32'h4, 32'h0010_0093, 1'b0);

      // 3: out-of-range and unaligned addresses
      request("t3_oor", 32'h1000, 32'h0, 1'b1);
      request("t3_unal", 32'h6, 32'h0010_0093, 1'b0);

      // 4: rd_addr changes during WAIT are ignored
      rd_addr = 32'h0; rd_enable = 1'b1;
      tick();
      rd_addr = 32'h4;
      tick();
      tick();
      check("t4_ready", {31'b0, rd_ready}, 32'd1);
      check("t4_data",  rd_data, 32'h0000_0013);
      rd_enable = 1'b0;
      tick();

      // 5: load colliding with RESP entry returns the old word
      rd_addr = 32'h8; rd_enable = 1'b1;
      tick();
      tick();
      ld_en = 1'b1; ld_addr = 32'h8; ld_data = 32'hDEAD_BEEF;
      tick();
      ld_en = 1'b0;
      check("t5_ready", {31'b0, rd_ready}, 32'd1);
      check("t5_old",   rd_data, 32'h1111_1111);
      rd_enable = 1'b0;
      tick();
      request("t5_new", 32'h8, 32'hDEAD_BEEF, 1'b0);

      // 6: reset during WAIT aborts; array contents survive
      rd_addr = 32'hC; rd_enable = 1'b1;
      tick();
      reset = 1'b1; rd_enable = 1'b0;
      tick();
      reset = 1'b0;
      check("t6_rst_ready", {31'b0, rd_ready}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t6_idle_ready", {31'b0, rd_ready}, 32'd0);
      end
      request("t6_word0", 32'h0, 32'h0000_0013, 1'b0);
      request("t6_wordc", 32'hC, 32'h0020_0113, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
